qix_vram_ctrl: RTL and testbench

Sequencer and arbiter in front of the 64 KB framebuffer's CPU port. It turns video-CPU bus requests into single-cycle BRAM strobes, holds the $9402/$9403 latched-address registers, and captures read data after the one-cycle BRAM latency. It also shares the port with an optional hardware fill engine that clears or paints all 65 536 bytes. It sits between the video-CPU address decode and the framebuffer.

---
 rtl/qix_pkg.sv | 27 ++
 rtl/qix_vram_fill.sv | 68 ++++++
 rtl/qix_vram_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_qix_vram_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qix_pkg.sv
// qix_pkg: types and constants shared by the framebuffer CPU-port controller.
//   vram_sel_t        - decoded video-CPU target (direct window, latched data,
//                       latched address high byte, latched address low byte)
//   vram_ctrl_state_t - sequencer states
//   VRAM_SIZE         - framebuffer size in bytes
//   FILL_CNT_W        - fill counter width: one address bit per byte plus a done flag
package qix_pkg;

  typedef enum logic [1:0] {
    DIRECT   = 2'd0,
    LDATA    = 2'd1,
    LADDR_HI = 2'd2,
    LADDR_LO = 2'd3
  } vram_sel_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    CAPTURE = 3'd2,
    ACK     = 3'd3,
    FILL    = 3'd4
  } vram_ctrl_state_t;

  localparam int unsigned VRAM_SIZE  = 65536;
  localparam int unsigned FILL_CNT_W = $clog2(VRAM_SIZE) + 1;

endpackage

// File: rtl/qix_vram_fill.sv
// qix_vram_fill: fill engine for the framebuffer. Present only when the
// QIX_VRAM_FILL_EN macro is defined.
//   clk, reset_n - clock, synchronous active-low reset (aborts a fill)
//   start        - pulse; begins a fill when idle, ignored while busy
//   value        - fill byte, captured on an accepted start
//   step         - the controller issued the write for addr this cycle
//   busy         - fill in progress
//   done         - every address has been issued; busy drops next cycle
//   addr         - next framebuffer address to write
//   fill_byte    - captured fill byte
`ifdef QIX_VRAM_FILL_EN
module qix_vram_fill
  import qix_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  value,
  input  logic        step,
  output logic        busy,
  output logic        done,
  output logic [15:0] addr,
  output logic [7:0]  fill_byte
);

  logic [FILL_CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]            value_q, value_d;
  logic                  busy_q, busy_d;

  always_comb begin
    cnt_d   = cnt_q;
    value_d = value_q;
    busy_d  = busy_q;
    if (busy_q) begin
      // The done flag is set by the step that issued address 0xFFFF, so busy
      // drops exactly one cycle after that write is on the bus.
      if (cnt_q[FILL_CNT_W-1]) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else if (step) begin
        cnt_d = cnt_q + FILL_CNT_W'(1);
      end
    end else if (start) begin
      busy_d  = 1'b1;
      value_d = value;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      value_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      value_q <= value_d;
      busy_q  <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign done      = cnt_q[FILL_CNT_W-1];
  assign addr      = cnt_q[15:0];
  assign fill_byte = value_q;

endmodule
`endif

// File: rtl/qix_vram_ctrl.sv
// qix_vram_ctrl: sequencer/arbiter in front of the framebuffer CPU port.
// Converts held video-CPU requests into single-cycle BRAM strobes, owns the
// $9402/$9403 latched-address registers and captures read data one cycle
// after the address is presented. Optional fill engine (macro
// QIX_VRAM_FILL_EN) shares the latched write path at lower priority.
//   clk, reset_n         - clock, synchronous active-low reset
//   cpu_req/rnw/sel      - held request, direction, target select
//   cpu_addr/cpu_din     - direct offset, write data
//   cpu_dout/cpu_ack     - read data (held), one-cycle completion pulse
//   fill_start/value     - fill trigger and byte; fill_busy status
//   vram_addr/we/din     - direct port (bank bit comes from latch hi[7])
//   vram_latch_*         - latched port address, strobe and data
//   vram_dout            - framebuffer port-A read register
// All vram_* outputs and cpu_ack are registered.
module qix_vram_ctrl
  import qix_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_rnw,
  input  logic [1:0]  cpu_sel,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        fill_start,
  input  logic [7:0]  fill_value,
  output logic        fill_busy,
  output logic [14:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_din,
  output logic [7:0]  vram_latch_addr_hi,
  output logic [7:0]  vram_latch_addr_lo,
  output logic        vram_latch_we,
  output logic [7:0]  vram_latch_din,
  input  logic [7:0]  vram_dout
);

  vram_ctrl_state_t state_q, state_d;
  vram_sel_t        sel;

  logic [7:0]  hi_q, hi_d, lo_q, lo_d;
  logic [7:0]  cpu_dout_q, cpu_dout_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [14:0] vram_addr_q, vram_addr_d;
  logic        vram_we_q, vram_we_d;
  logic [7:0]  vram_din_q, vram_din_d;
  logic [7:0]  latch_hi_q, latch_hi_d, latch_lo_q, latch_lo_d;
  logic        latch_we_q, latch_we_d;
  logic [7:0]  latch_din_q, latch_din_d;

  logic        fill_busy_w, fill_pending, fill_issue;
  logic [15:0] fill_addr_w;
  logic [7:0]  fill_byte_w;

  assign sel = vram_sel_t'(cpu_sel);

`ifdef QIX_VRAM_FILL_EN
  logic fill_done_w;

  qix_vram_fill u_fill (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (fill_start),
    .value     (fill_value),
    .step      (fill_issue),
    .busy      (fill_busy_w),
    .done      (fill_done_w),
    .addr      (fill_addr_w),
    .fill_byte (fill_byte_w)
  );

  assign fill_pending = fill_busy_w & ~fill_done_w;
`else
  logic unused_fill;
  assign unused_fill  = ^{fill_start, fill_value};
  assign fill_busy_w  = 1'b0;
  assign fill_pending = 1'b0;
  assign fill_addr_w  = '0;
  assign fill_byte_w  = '0;
`endif

  // A fill byte is issued only when the CPU is not requesting; cpu_req rising
  // during FILL suppresses the write and the counter step in the same cycle.
  assign fill_issue = fill_pending & ~cpu_req & ((state_q == IDLE) | (state_q == FILL));

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          if (sel == LADDR_HI || sel == LADDR_LO) state_d = ACK;
          else                                    state_d = ISSUE;
        end else if (fill_issue) begin
          state_d = FILL;
        end
      end
      ISSUE:   state_d = cpu_rnw ? CAPTURE : ACK;
      CAPTURE: state_d = ACK;
      ACK:     state_d = IDLE;
      FILL:    state_d = fill_issue ? FILL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and latch registers
  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    cpu_dout_d  = cpu_dout_q;
    cpu_ack_d   = (state_d == ACK);
    vram_addr_d = vram_addr_q;
    vram_we_d   = 1'b0;
    vram_din_d  = vram_din_q;
    latch_we_d  = 1'b0;
    latch_din_d = latch_din_q;

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          case (sel)
            LADDR_HI: begin
              if (cpu_rnw) cpu_dout_d = hi_q;
              else         hi_d       = cpu_din;
            end
            LADDR_LO: begin
              if (cpu_rnw) cpu_dout_d = lo_q;
              else         lo_d       = cpu_din;
            end
            DIRECT: begin
              vram_addr_d = cpu_addr;
              if (!cpu_rnw) begin
                vram_we_d  = 1'b1;
                vram_din_d = cpu_din;
              end
            end
            default: begin // LDATA
              if (cpu_rnw) begin
                // Port-A falls back to the direct path when no latched write
                // is active, so present the latched address there.
                vram_addr_d = {hi_q[6:0], lo_q};
              end else begin
                latch_we_d  = 1'b1;
                latch_din_d = cpu_din;
              end
            end
          endcase
        end
      end
      CAPTURE: cpu_dout_d = vram_dout;
      default: ;
    endcase

    if (fill_issue) begin
      latch_we_d  = 1'b1;
      latch_din_d = fill_byte_w;
    end

    // Latch address outputs follow the CPU registers except on fill writes.
    latch_hi_d = fill_issue ? fill_addr_w[15:8] : hi_d;
    latch_lo_d = fill_issue ? fill_addr_w[7:0]  : lo_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hi_q        <= '0;
      lo_q        <= '0;
      cpu_dout_q  <= '0;
      cpu_ack_q   <= 1'b0;
      vram_addr_q <= '0;
      vram_we_q   <= 1'b0;
      vram_din_q  <= '0;
      latch_hi_q  <= '0;
      latch_lo_q  <= '0;
      latch_we_q  <= 1'b0;
      latch_din_q <= '0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ack_q   <= cpu_ack_d;
      vram_addr_q <= vram_addr_d;
      vram_we_q   <= vram_we_d;
      vram_din_q  <= vram_din_d;
      latch_hi_q  <= latch_hi_d;
      latch_lo_q  <= latch_lo_d;
      latch_we_q  <= latch_we_d;
      latch_din_q <= latch_din_d;
    end
  end

  assign cpu_dout           = cpu_dout_q;
  assign cpu_ack            = cpu_ack_q;
  assign fill_busy          = fill_busy_w;
  assign vram_addr          = vram_addr_q;
  assign vram_we            = vram_we_q;
  assign vram_din           = vram_din_q;
  assign vram_latch_addr_hi = latch_hi_q;
  assign vram_latch_addr_lo = latch_lo_q;
  assign vram_latch_we      = latch_we_q;
  assign vram_latch_din     = latch_din_q;

endmodule

// File: tb/tb_qix_vram_ctrl.sv
// tb_qix_vram_ctrl: self-checking bench for qix_vram_ctrl. A table of CPU
// accesses with hand-computed results is applied against a behavioural
// framebuffer, followed by hand-written sequences for reset mid-read and,
// when QIX_VRAM_FILL_EN is defined, the fill engine corner cases.
module tb_qix_vram_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_rnw;
  logic [1:0]  cpu_sel;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        fill_start;
  logic [7:0]  fill_value;
  logic        fill_busy;
  logic [14:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_din;
  logic [7:0]  vram_latch_addr_hi, vram_latch_addr_lo;
  logic        vram_latch_we;
  logic [7:0]  vram_latch_din;
  logic [7:0]  vram_dout;

  always #5 clk = ~clk;

  qix_vram_ctrl dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .cpu_req            (cpu_req),
    .cpu_rnw            (cpu_rnw),
    .cpu_sel            (cpu_sel),
    .cpu_addr           (cpu_addr),
    .cpu_din            (cpu_din),
    .cpu_dout           (cpu_dout),
    .cpu_ack            (cpu_ack),
    .fill_start         (fill_start),
    .fill_value         (fill_value),
    .fill_busy          (fill_busy),
    .vram_addr          (vram_addr),
    .vram_we            (vram_we),
    .vram_din           (vram_din),
    .vram_latch_addr_hi (vram_latch_addr_hi),
    .vram_latch_addr_lo (vram_latch_addr_lo),
    .vram_latch_we      (vram_latch_we),
    .vram_latch_din     (vram_latch_din),
    .vram_dout          (vram_dout)
  );

  // Behavioural framebuffer port A: latched write wins the mux, otherwise the
  // direct path with the bank bit from the latched high byte; registered read.
  logic [7:0]  mem [0:65535];
  logic [15:0] pa_addr;
  assign pa_addr = vram_latch_we ? {vram_latch_addr_hi, vram_latch_addr_lo}
                                 : {vram_latch_addr_hi[7], vram_addr};
  always @(posedge clk) begin
    if (vram_latch_we)  mem[pa_addr] <= vram_latch_din;
    else if (vram_we)   mem[pa_addr] <= vram_din;
    vram_dout <= mem[pa_addr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {5'd0, cpu_dout, cpu_ack, fill_busy, vram_addr, vram_we, vram_din,
            vram_latch_addr_hi, vram_latch_addr_lo, vram_latch_we, vram_latch_din};
  endfunction

  typedef struct {
    logic [1:0]  sel;
    logic        rnw;
    logic [14:0] addr;
    logic [7:0]  din;
    int          lat;
    logic [7:0]  dout;
    int          n_we;
    int          n_lwe;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic [14:0] raddr;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } vec_t;

  typedef struct {
    int          lat;
    logic [7:0]  dout;
    int          n_we;
    int          n_lwe;
    logic [15:0] waddr;
    logic [7:0]  wdata;
    logic [14:0] raddr;
    logic [7:0]  hi;
    logic [7:0]  lo;
  } res_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [1:0] sel, input logic rnw, input logic [14:0] addr,
                              input logic [7:0] din, input int lat, input logic [7:0] dout,
                              input int n_we, input int n_lwe, input logic [15:0] waddr,
                              input logic [7:0] wdata, input logic [14:0] raddr,
                              input logic [7:0] hi, input logic [7:0] lo);
    vec_t v;
    v.sel = sel; v.rnw = rnw; v.addr = addr; v.din = din; v.lat = lat; v.dout = dout;
    v.n_we = n_we; v.n_lwe = n_lwe; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
    v.hi = hi; v.lo = lo;
    return v;
  endfunction

  // One CPU access starting in the next cycle; samples #1 after each edge.
  task automatic cpu_access(input logic [1:0] sel, input logic rnw, input logic [14:0] addr,
                            input logic [7:0] din, output res_t r);
    r.lat = -1; r.dout = '0; r.n_we = 0; r.n_lwe = 0;
    r.waddr = '0; r.wdata = '0; r.raddr = '0; r.hi = '0; r.lo = '0;
    @(posedge clk); #1;
    cpu_sel = sel; cpu_rnw = rnw; cpu_addr = addr; cpu_din = din; cpu_req = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) r.raddr = vram_addr;
      if (vram_we) begin
        r.n_we++; r.waddr = {vram_latch_addr_hi[7], vram_addr}; r.wdata = vram_din;
      end
      if (vram_latch_we) begin
        r.n_lwe++; r.waddr = {vram_latch_addr_hi, vram_latch_addr_lo}; r.wdata = vram_latch_din;
      end
      if (cpu_ack) begin
        r.lat = c; r.dout = cpu_dout;
        r.hi = vram_latch_addr_hi; r.lo = vram_latch_addr_lo;
        cpu_req = 1'b0;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  res_t r;
  int   acks, busy_seen, lwe_seen;
`ifdef QIX_VRAM_FILL_EN
  int          nwr, seq_err, data_err, last_wr, busy_low, req_cyc, pre_lat, pause_wr;
  logic [16:0] exp_a;
  logic [7:0]  pre_dout;
  logic [15:0] pause_hilo, resume_addr, first_addr;
  logic        resumed, first_seen;
`endif

  initial begin
    reset_n = 1'b0; cpu_req = 1'b0; cpu_rnw = 1'b0; cpu_sel = 2'd0;
    cpu_addr = '0; cpu_din = '0; fill_start = 1'b0; fill_value = '0;

    //         sel   rnw  addr      din    lat dout   we lwe waddr      wdata  raddr     hi     lo
    vecs[0]  = mk(2'd2, 1'b0, 15'h0,    8'h9A, 1, 8'h00, 0, 0, 16'h0,    8'h00, 15'h0,    8'h9A, 8'h00);
    vecs[1]  = mk(2'd3, 1'b0, 15'h0,    8'h3C, 1, 8'h00, 0, 0, 16'h0,    8'h00, 15'h0,    8'h9A, 8'h3C);
    vecs[2]  = mk(2'd2, 1'b1, 15'h0,    8'h00, 1, 8'h9A, 0, 0, 16'h0,    8'h00, 15'h0,    8'h9A, 8'h3C);
    vecs[3]  = mk(2'd3, 1'b1, 15'h0,    8'h00, 1, 8'h3C, 0, 0, 16'h0,    8'h00, 15'h0,    8'h9A, 8'h3C);
    vecs[4]  = mk(2'd1, 1'b0, 15'h0,    8'h5A, 2, 8'h00, 0, 1, 16'h9A3C, 8'h5A, 15'h0,    8'h9A, 8'h3C);
    vecs[5]  = mk(2'd1, 1'b1, 15'h0,    8'h00, 3, 8'h5A, 0, 0, 16'h0,    8'h00, 15'h1A3C, 8'h9A, 8'h3C);
    vecs[6]  = mk(2'd2, 1'b0, 15'h0,    8'h80, 1, 8'h00, 0, 0, 16'h0,    8'h00, 15'h0,    8'h80, 8'h3C);
    vecs[7]  = mk(2'd0, 1'b0, 15'h1234, 8'hC3, 2, 8'h00, 1, 0, 16'h9234, 8'hC3, 15'h0,    8'h80, 8'h3C);
    vecs[8]  = mk(2'd0, 1'b1, 15'h1234, 8'h00, 3, 8'hC3, 0, 0, 16'h0,    8'h00, 15'h1234, 8'h80, 8'h3C);
    vecs[9]  = mk(2'd2, 1'b0, 15'h0,    8'h00, 1, 8'h00, 0, 0, 16'h0,    8'h00, 15'h0,    8'h00, 8'h3C);
    vecs[10] = mk(2'd0, 1'b0, 15'h1234, 8'h3D, 2, 8'h00, 1, 0, 16'h1234, 8'h3D, 15'h0,    8'h00, 8'h3C);
    vecs[11] = mk(2'd0, 1'b1, 15'h1234, 8'h00, 3, 8'h3D, 0, 0, 16'h0,    8'h00, 15'h1234, 8'h00, 8'h3C);
    vecs[12] = mk(2'd2, 1'b0, 15'h0,    8'h80, 1, 8'h00, 0, 0, 16'h0,    8'h00, 15'h0,    8'h80, 8'h3C);
    vecs[13] = mk(2'd0, 1'b1, 15'h1234, 8'h00, 3, 8'hC3, 0, 0, 16'h0,    8'h00, 15'h1234, 8'h80, 8'h3C);
    vecs[14] = mk(2'd0, 1'b0, 15'h7FFF, 8'h11, 2, 8'h00, 1, 0, 16'hFFFF, 8'h11, 15'h0,    8'h80, 8'h3C);
    vecs[15] = mk(2'd2, 1'b0, 15'h0,    8'hFF, 1, 8'h00, 0, 0, 16'h0,    8'h00, 15'h0,    8'hFF, 8'h3C);
    vecs[16] = mk(2'd3, 1'b0, 15'h0,    8'hFF, 1, 8'h00, 0, 0, 16'h0,    8'h00, 15'h0,    8'hFF, 8'hFF);
    vecs[17] = mk(2'd1, 1'b1, 15'h0,    8'h00, 3, 8'h11, 0, 0, 16'h0,    8'h00, 15'h7FFF, 8'hFF, 8'hFF);
    vecs[18] = mk(2'd1, 1'b0, 15'h0,    8'hEE, 2, 8'h00, 0, 1, 16'hFFFF, 8'hEE, 15'h0,    8'hFF, 8'hFF);
    vecs[19] = mk(2'd0, 1'b1, 15'h7FFF, 8'h00, 3, 8'hEE, 0, 0, 16'h0,    8'h00, 15'h7FFF, 8'hFF, 8'hFF);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    reset_n = 1'b1;

    // Table-driven CPU accesses
    for (int i = 0; i < NV; i++) begin
      cpu_access(vecs[i].sel, vecs[i].rnw, vecs[i].addr, vecs[i].din, r);
      $display("[TB] vec %0d sel=%0d rnw=%0d lat=%0d dout=0x%02h we=%0d lwe=%0d",
               i, vecs[i].sel, vecs[i].rnw, r.lat, r.dout, r.n_we, r.n_lwe);
      check($sformatf("v%0d_latency", i), 64'(r.lat), 64'(vecs[i].lat));
      check($sformatf("v%0d_we_count", i), 64'(r.n_we), 64'(vecs[i].n_we));
      check($sformatf("v%0d_lwe_count", i), 64'(r.n_lwe), 64'(vecs[i].n_lwe));
      check($sformatf("v%0d_latch_hi", i), 64'(r.hi), 64'(vecs[i].hi));
      check($sformatf("v%0d_latch_lo", i), 64'(r.lo), 64'(vecs[i].lo));
      if (vecs[i].rnw)
        check($sformatf("v%0d_dout", i), 64'(r.dout), 64'(vecs[i].dout));
      if (vecs[i].sel < 2'd2 && !vecs[i].rnw) begin
        check($sformatf("v%0d_waddr", i), 64'(r.waddr), 64'(vecs[i].waddr));
        check($sformatf("v%0d_wdata", i), 64'(r.wdata), 64'(vecs[i].wdata));
      end
      if (vecs[i].sel < 2'd2 && vecs[i].rnw)
        check($sformatf("v%0d_raddr", i), 64'(r.raddr), 64'(vecs[i].raddr));
    end

    // Reset while a latched read is in CAPTURE: no ack, everything cleared
    @(posedge clk); #1;
    cpu_sel = 2'd1; cpu_rnw = 1'b1; cpu_req = 1'b1;      // cycle N
    @(posedge clk); #1;                                   // N+1 ISSUE
    @(posedge clk); #1;                                   // N+2 CAPTURE
    reset_n = 1'b0;
    acks = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) check("rst_read_outputs", all_outs(), 64'd0);
      if (cpu_ack) acks++;
      if (c == 1) cpu_req = 1'b0;
    end
    check("rst_read_no_ack", 64'(acks), 64'd0);
    reset_n = 1'b1;
    cpu_access(2'd2, 1'b1, 15'h0, 8'h00, r);
    check("rst_read_hi_cleared", 64'(r.dout), 64'h00);
    cpu_access(2'd3, 1'b1, 15'h0, 8'h00, r);
    check("rst_read_lo_cleared", 64'(r.dout), 64'h00);

    // Latch registers for the fill section
    cpu_access(2'd2, 1'b0, 15'h0, 8'h12, r);
    cpu_access(2'd3, 1'b0, 15'h0, 8'h34, r);
    check("setup_hilo", {48'd0, r.hi, r.lo}, 64'h1234);

`ifdef QIX_VRAM_FILL_EN
    // Full fill with CPU pre-emption at 0x0100 and a redundant start
    @(posedge clk); #1;
    fill_value = 8'h00; fill_start = 1'b1;
    @(posedge clk); #1;
    fill_start = 1'b0;
    check("fill_busy_set", 64'(fill_busy), 64'd1);
    exp_a = '0; nwr = 0; seq_err = 0; data_err = 0; last_wr = 0; busy_low = -1;
    req_cyc = -1; pre_lat = -1; pre_dout = '0; pause_wr = 0; pause_hilo = '0;
    resume_addr = '0; resumed = 1'b0;
    for (int cyc = 1; cyc <= 70000; cyc++) begin
      @(posedge clk); #1;
      fill_start = 1'b0;
      if (!fill_busy) begin busy_low = cyc; break; end
      if (cpu_ack && req_cyc >= 0 && pre_lat < 0) begin
        pre_lat = cyc - req_cyc; pre_dout = cpu_dout;
        pause_hilo = {vram_latch_addr_hi, vram_latch_addr_lo};
        cpu_req = 1'b0;
      end
      if (vram_latch_we) begin
        if ({vram_latch_addr_hi, vram_latch_addr_lo} != exp_a[15:0]) seq_err++;
        if (vram_latch_din != 8'h00) data_err++;
        if (req_cyc >= 0 && pre_lat < 0) pause_wr++;
        if (pre_lat >= 0 && !resumed) begin
          resumed = 1'b1; resume_addr = {vram_latch_addr_hi, vram_latch_addr_lo};
        end
        exp_a = exp_a + 17'd1; nwr++; last_wr = cyc;
        if (exp_a == 17'h0100 && req_cyc < 0) begin
          cpu_sel = 2'd1; cpu_rnw = 1'b1; cpu_req = 1'b1; req_cyc = cyc;
        end
        if (exp_a == 17'h8000) begin fill_value = 8'hFF; fill_start = 1'b1; end
      end
    end
    cpu_req = 1'b0;
    $display("[TB] fill writes=%0d last=%0d busy_low=%0d preempt_lat=%0d", nwr, last_wr, busy_low, pre_lat);
    check("fill_write_count", 64'(nwr), 64'd65536);
    check("fill_addr_sequence_errs", 64'(seq_err), 64'd0);
    check("fill_data_errs", 64'(data_err), 64'd0);
    check("fill_busy_clear_delay", 64'(busy_low - last_wr), 64'd1);
    check("preempt_ack_latency", 64'(pre_lat), 64'd4);
    check("preempt_read_data", 64'(pre_dout), 64'h3D);
    check("preempt_fill_paused", 64'(pause_wr), 64'd0);
    check("preempt_hilo_unchanged", 64'(pause_hilo), 64'h1234);
    check("fill_resume_addr", 64'(resume_addr), 64'h0100);
    cpu_access(2'd1, 1'b1, 15'h0, 8'h00, r);
    check("post_fill_readback", 64'(r.dout), 64'h00);
    cpu_access(2'd2, 1'b1, 15'h0, 8'h00, r);
    check("post_fill_hi_reg", 64'(r.dout), 64'h12);

    // Reset at fill address 0x4000
    @(posedge clk); #1;
    fill_value = 8'h55; fill_start = 1'b1;
    first_seen = 1'b0; first_addr = '0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(posedge clk); #1;
      fill_start = 1'b0;
      if (vram_latch_we) begin
        if (!first_seen) begin first_seen = 1'b1; first_addr = {vram_latch_addr_hi, vram_latch_addr_lo}; end
        if ({vram_latch_addr_hi, vram_latch_addr_lo} == 16'h4000) break;
      end
    end
    check("fill2_first_addr", 64'(first_addr), 64'h0000);
    check("fill2_reached_4000", {48'd0, vram_latch_addr_hi, vram_latch_addr_lo}, 64'h4000);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_fill_outputs", all_outs(), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    busy_seen = 0; lwe_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (fill_busy) busy_seen++;
      if (vram_latch_we) lwe_seen++;
    end
    check("rst_fill_busy_stays_low", 64'(busy_seen), 64'd0);
    check("rst_fill_no_writes", 64'(lwe_seen), 64'd0);
    cpu_access(2'd2, 1'b1, 15'h0, 8'h00, r);
    check("rst_fill_hi_cleared", 64'(r.dout), 64'h00);

    // Counter restarts from zero after an aborted fill
    @(posedge clk); #1;
    fill_value = 8'hA5; fill_start = 1'b1;
    first_seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      fill_start = 1'b0;
      if (vram_latch_we) begin
        first_seen = 1'b1;
        first_addr = {vram_latch_addr_hi, vram_latch_addr_lo};
        check("fill3_first_data", 64'(vram_latch_din), 64'hA5);
        break;
      end
    end
    check("fill3_started", 64'(first_seen), 64'd1);
    check("fill3_first_addr", 64'(first_addr), 64'h0000);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
`else
    // Fill engine absent: start pulse has no effect
    @(posedge clk); #1;
    fill_value = 8'hFF; fill_start = 1'b1;
    busy_seen = 0; lwe_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      fill_start = 1'b0;
      if (fill_busy) busy_seen++;
      if (vram_latch_we) lwe_seen++;
    end
    check("nofill_busy_low", 64'(busy_seen), 64'd0);
    check("nofill_no_writes", 64'(lwe_seen), 64'd0);
    check("nofill_latch_outputs", {48'd0, vram_latch_addr_hi, vram_latch_addr_lo}, 64'h1234);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
